// File: rtl/seven_led_scan_ctrl_if.sv
// Load bus for the 7-segment scan controller: write strobe plus the digit,
// mask and leading-zero values captured into the shadow registers.
interface seven_led_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      i_wr_en;
    logic [4*NUM_DIGITS-1:0]   i_digits;
    logic [NUM_DIGITS-1:0]     i_blank_mask;
    logic [NUM_DIGITS-1:0]     i_blink_mask;
    logic                      i_lz_en;

    modport master (
        output i_wr_en,
        output i_digits,
        output i_blank_mask,
        output i_blink_mask,
        output i_lz_en
    );

    modport slave (
        input  i_wr_en,
        input  i_digits,
        input  i_blank_mask,
        input  i_blink_mask,
        input  i_lz_en
    );
endinterface

// File: rtl/seven_led_scan_ctrl.sv
// N-digit hex 7-segment controller: shadow digit registers, active-low decode with
// blanking, leading-zero suppression and blinking, parallel and scanned outputs.
module seven_led_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    seven_led_scan_ctrl_if.slave    wr_bus,
    output logic [7*NUM_DIGITS-1:0] o_hex,
    output logic [6:0]              o_scan_seg,
    output logic [NUM_DIGITS-1:0]   o_scan_an,
    output logic                    o_blink_phase
);

    localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] digits_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [NUM_DIGITS-1:0]   blink_reg;
    logic                    lz_reg;

    logic [SCAN_W-1:0]       scan_cnt_reg,  scan_cnt_next;
    logic [IDX_W-1:0]        scan_idx_reg,  scan_idx_next;
    logic [BLINK_W-1:0]      blink_cnt_reg, blink_cnt_next;
    logic                    phase_reg,     phase_next;

    logic [7*NUM_DIGITS-1:0] hex_reg,       hex_next;
    logic [6:0]              scan_seg_reg,  scan_seg_next;
    logic [NUM_DIGITS-1:0]   scan_an_reg,   scan_an_next;

    logic [NUM_DIGITS-1:0]   zero_tail;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_next  = (scan_cnt_reg == SCAN_LAST) ? '0 : scan_cnt_reg + SCAN_W'(1);
        scan_idx_next  = scan_idx_reg;
        if (scan_cnt_reg == SCAN_LAST) begin
            scan_idx_next = (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + IDX_W'(1);
        end
        blink_cnt_next = (blink_cnt_reg == BLINK_LAST) ? '0 : blink_cnt_reg + BLINK_W'(1);
        phase_next     = (blink_cnt_reg == BLINK_LAST) ? ~phase_reg : phase_reg;
    end

    // zero_tail[k]: shadow digits k..N-1 are all zero (walked from the top digit down)
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_tail = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run          = run & (digits_reg[4*k +: 4] == 4'h0);
            zero_tail[k] = run;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic lz_dark;
            if (gi == 0) begin : g_first
                assign lz_dark = 1'b0;
            end else begin : g_upper
                assign lz_dark = lz_reg & zero_tail[gi];
            end

            always_comb begin
                if (blank_reg[gi] || lz_dark || (blink_reg[gi] && phase_next)) begin
                    hex_next[7*gi +: 7] = 7'h7F;
                end else begin
                    hex_next[7*gi +: 7] = seg_decode(digits_reg[4*gi +: 4]);
                end
            end
        end
    endgenerate

    // Scan outputs use the same next index and next decode as o_hex, so they never skew
    always_comb begin
        scan_seg_next = 7'h7F;
        scan_an_next  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx_next == IDX_W'(k)) begin
                scan_seg_next   = hex_next[7*k +: 7];
                scan_an_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            digits_reg    <= '0;
            blank_reg     <= '0;
            blink_reg     <= '0;
            lz_reg        <= 1'b0;
            scan_cnt_reg  <= '0;
            scan_idx_reg  <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            hex_reg       <= '1;
            scan_seg_reg  <= 7'h7F;
            scan_an_reg   <= '1;
        end else begin
            if (wr_bus.i_wr_en) begin
                digits_reg <= wr_bus.i_digits;
                blank_reg  <= wr_bus.i_blank_mask;
                blink_reg  <= wr_bus.i_blink_mask;
                lz_reg     <= wr_bus.i_lz_en;
            end
            scan_cnt_reg  <= scan_cnt_next;
            scan_idx_reg  <= scan_idx_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            hex_reg       <= hex_next;
            scan_seg_reg  <= scan_seg_next;
            scan_an_reg   <= scan_an_next;
        end
    end

    assign o_hex         = hex_reg;
    assign o_scan_seg    = scan_seg_reg;
    assign o_scan_an     = scan_an_reg;
    assign o_blink_phase = phase_reg;

endmodule
